// File: rtl/if_stage_if.sv
// Signal bundle between the instruction-fetch stage and its environment (ID control, imem, IF/ID).
// The slave side is the fetch stage; the master side drives control, targets and imem data.
interface if_stage_if;
  logic        PCWrite;
  logic        IFFlush;
  logic [2:0]  pcsrc;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] IFID_instr;
  logic [31:0] IFID_pcplus4;
  logic        IFID_valid;
  logic [15:0] stall_cnt;

  modport master (
    output PCWrite, IFFlush, pcsrc, branch_target, jump_target, jr_target, imem_data,
    input  imem_addr, pc, IFID_instr, IFID_pcplus4, IFID_valid, stall_cnt
  );

  modport slave (
    input  PCWrite, IFFlush, pcsrc, branch_target, jump_target, jr_target, imem_data,
    output imem_addr, pc, IFID_instr, IFID_pcplus4, IFID_valid, stall_cnt
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register with next-PC selection, IF/ID pipeline register
// with bubble insertion, and a saturating stall counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input logic     clk,
  input logic     reset,
  if_stage_if.slave bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [15:0] stall_q, stall_d;
  logic [31:0] pcplus4;
  logic        redirect;
  logic        bubble;

  // Bit 31 is the supervisor bit; only the low 31 bits advance.
  assign pcplus4 = {pc_q[31], pc_q[30:0] + 31'd4};

  always_comb begin
    pc_d     = pc_q;
    redirect = 1'b0;
    if (bus.PCWrite) begin
      case (bus.pcsrc)
        3'b001: begin
          pc_d     = bus.branch_target;
          redirect = 1'b1;
        end
        3'b010: begin
          pc_d     = bus.jump_target;
          redirect = 1'b1;
        end
        3'b011: begin
          pc_d     = bus.jr_target;
          redirect = 1'b1;
        end
        3'b100: begin
          pc_d     = ILLOP_PC;
          redirect = 1'b1;
        end
        3'b101: begin
          pc_d     = XADR_PC;
          redirect = 1'b1;
        end
        default: pc_d = pcplus4;
      endcase
    end
  end

  assign bubble = bus.IFFlush | redirect;

  always_comb begin
    instr_d = bus.imem_data;
    pcp4_d  = pcplus4;
    valid_d = 1'b1;
    if (bubble) begin
      instr_d = 32'h0;
      pcp4_d  = 32'h0;
      valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!bus.PCWrite && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pcp4_q  <= 32'h0;
      valid_q <= 1'b0;
      stall_q <= 16'h0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.imem_addr    = pc_q;
  assign bus.IFID_instr   = instr_q;
  assign bus.IFID_pcplus4 = pcp4_q;
  assign bus.IFID_valid   = valid_q;
  assign bus.stall_cnt    = stall_q;

endmodule
